voice_mixer: RTL

//  Downstream of the per-voice oscillators. On each audio-rate tick, snapshots every voice's sample index,

---
 rtl/mixer_pkg.sv | 18 +
 rtl/voice_mac.sv | 44 ++++
 rtl/voice_mixer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mixer_pkg.sv
// Shared types, constants and output saturation for the voice mixer.
package mixer_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUTPUT} mix_state_t;

   localparam int SAMPLE_W  = 16;
   localparam int OUT_SHIFT = 8;

   function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
      if (v > 32'sd32767)
         sat16 = 16'sh7fff;
      else if (v < -32'sd32768)
         sat16 = 16'sh8000;
      else
         sat16 = $signed(v[SAMPLE_W-1:0]);
   endfunction

endpackage

// File: rtl/voice_mac.sv
// Signed multiply-accumulate of a waveform sample by an unsigned voice gain.
module voice_mac
   import mixer_pkg::*;
#(
   parameter int GAIN_WIDTH = 8,
   parameter int ACC_W      = 27
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       clear_in,
   input  logic                       en_in,
   input  logic signed [SAMPLE_W-1:0] data_in,
   input  logic [GAIN_WIDTH-1:0]      gain_in,
   output logic signed [ACC_W-1:0]    acc_out
);

   localparam int PROD_W = SAMPLE_W + GAIN_WIDTH + 1;

   logic signed [GAIN_WIDTH:0] gain_s;
   logic signed [PROD_W-1:0]   prod;
   logic signed [ACC_W-1:0]    acc_q, acc_d;

   // Zero-extend the gain so it multiplies as a non-negative signed value.
   assign gain_s = $signed({1'b0, gain_in});
   assign prod   = PROD_W'(data_in) * PROD_W'(gain_s);

   always_comb begin
      acc_d = acc_q;
      if (clear_in)
         acc_d = '0;
      else if (en_in)
         acc_d = acc_q + ACC_W'(prod);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         acc_q <= '0;
      else
         acc_q <= acc_d;
   end

   assign acc_out = acc_q;

endmodule

// File: rtl/voice_mixer.sv
// Per-tick voice mixer: snapshots voice state, reads each voice's sample from
// the shared waveform BRAM, scales by gain, sums and emits one saturated sample.
module voice_mixer
   import mixer_pkg::*;
#(
   parameter  int NUM_VOICES  = 4,
   parameter  int WW_WIDTH    = 16,
   parameter  int GAIN_WIDTH  = 8,
   parameter  int RAM_LATENCY = 2,
   localparam int VID_W       = $clog2(NUM_VOICES)
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic                             sample_tick_in,
   input  logic [NUM_VOICES-1:0]            voice_on_in,
   input  logic [NUM_VOICES*WW_WIDTH-1:0]   sample_index_in,
   input  logic [NUM_VOICES*GAIN_WIDTH-1:0] gain_in,
   output logic [VID_W+WW_WIDTH-1:0]        ram_addr_out,
   input  logic signed [SAMPLE_W-1:0]       ram_data_in,
   output logic signed [SAMPLE_W-1:0]       mix_out,
   output logic                             mix_valid_out,
   output logic                             busy_out,
   output logic                             overrun_out
);

   localparam int ACC_W = SAMPLE_W + GAIN_WIDTH + 1 + VID_W;

   mix_state_t state_q, state_d;
   logic [VID_W-1:0] k_q, k_d;
   logic             snap, clear_acc, pending;

   logic [NUM_VOICES-1:0]                 on_snap_q;
   logic [NUM_VOICES-1:0][WW_WIDTH-1:0]   idx_snap_q;
   logic [NUM_VOICES-1:0][GAIN_WIDTH-1:0] gain_snap_q;

   logic [RAM_LATENCY-1:0]            tag_vld_q;
   logic [RAM_LATENCY-1:0][VID_W-1:0] tag_id_q;
   logic [VID_W-1:0]                  ret_id;
   logic                              mac_en;

   logic signed [ACC_W-1:0]    acc;
   logic signed [31:0]         acc_ext;
   logic signed [SAMPLE_W-1:0] mix_q;
   logic                       valid_q, ovr_q;

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      snap      = 1'b0;
      clear_acc = 1'b0;
      case (state_q)
         IDLE: begin
            if (sample_tick_in) begin
               snap      = 1'b1;
               clear_acc = 1'b1;
               k_d       = '0;
               state_d   = FETCH;
            end
         end
         FETCH: begin
            k_d = k_q + VID_W'(1);
            if (k_q == VID_W'(NUM_VOICES - 1))
               state_d = DRAIN;
         end
         DRAIN: begin
            if (!pending)
               state_d = OUTPUT;
         end
         OUTPUT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Only the last tag stage may still be in flight when leaving DRAIN; it retires on that edge.
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < RAM_LATENCY - 1; i++)
         pending = pending | tag_vld_q[i];
   end

   always_ff @(posedge clk_in) begin
      if (snap) begin
         on_snap_q   <= voice_on_in;
         idx_snap_q  <= sample_index_in;
         gain_snap_q <= gain_in;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         tag_vld_q <= '0;
         tag_id_q  <= '0;
      end else begin
         tag_vld_q[0] <= (state_q == FETCH);
         tag_id_q[0]  <= k_q;
         for (int i = 1; i < RAM_LATENCY; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_id_q[i]  <= tag_id_q[i-1];
         end
      end
   end

   assign ret_id = tag_id_q[RAM_LATENCY-1];
   // Disabled voices still occupy a read slot but never reach the accumulator.
   assign mac_en = tag_vld_q[RAM_LATENCY-1] & on_snap_q[ret_id];

   voice_mac #(
      .GAIN_WIDTH (GAIN_WIDTH),
      .ACC_W      (ACC_W)
   ) u_mac (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .clear_in (clear_acc),
      .en_in    (mac_en),
      .data_in  (ram_data_in),
      .gain_in  (gain_snap_q[ret_id]),
      .acc_out  (acc)
   );

   assign acc_ext = 32'(acc);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         k_q     <= '0;
         mix_q   <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         valid_q <= (state_q == OUTPUT);
         ovr_q   <= sample_tick_in && (state_q != IDLE);
         if (state_q == OUTPUT)
            mix_q <= sat16(acc_ext >>> OUT_SHIFT);
      end
   end

   assign ram_addr_out  = (state_q == FETCH) ? {k_q, idx_snap_q[k_q]} : '0;
   assign mix_out       = mix_q;
   assign mix_valid_out = valid_q;
   assign busy_out      = (state_q != IDLE);
   assign overrun_out   = ovr_q;

endmodule
